// File: rtl/apb_interconnect_n_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_interconnect_n_if : request/response port plus shared APB bus         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface apb_interconnect_n_if #(
    parameter int NUM_SLAVES = 6,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic [ADDR_W-1:0]            PADDR;
    logic                         PWRITE;
    logic [DATA_W-1:0]            PWDATA;
    logic                         PENABLE;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    // Bridge side: accepts requests, drives the APB bus.
    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PWRITE, PWDATA, PENABLE, PSEL,
        input  PRDATA, PREADY, PSLVERR
    );

    // Environment side: requester plus the peripheral slaves.
    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PWRITE, PWDATA, PENABLE, PSEL,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_interconnect_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_interconnect_n : single-request APB bridge + decoder for N slaves     |
// | Optional ACCESS-phase watchdog: define APB_TIMEOUT_EN                     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module apb_interconnect_n #(
    parameter int NUM_SLAVES     = 6,
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int IDX_W          = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    apb_interconnect_n_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } state_t;

    localparam logic [IDX_W:0] c_num_slaves = (IDX_W+1)'(NUM_SLAVES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_req_idx;
    logic                  w_req_hit;
    logic                  w_accept;
    logic [NUM_SLAVES-1:0] w_psel_idx;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_W-1:0]     w_sel_rdata;
    logic                  w_timeout;
    logic                  w_rsp_fire;
    logic                  w_rsp_err;
    logic [DATA_W-1:0]     w_rsp_rdata;

    assign w_req_idx     = bus.req_addr[ADDR_W-1 -: IDX_W];
    assign w_req_hit     = ({1'b0, w_req_idx} < c_num_slaves);
    assign bus.req_ready = (r_state == IDLE) && !rst;
    assign w_accept      = bus.req_valid && bus.req_ready;

    // Only the latched slave's ready/error/data are ever looked at.
    always_comb begin
        w_psel_idx  = '0;
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_psel_idx[i] = 1'b1;
                w_sel_ready   = bus.PREADY[i];
                w_sel_err     = bus.PSLVERR[i];
                w_sel_rdata   = bus.PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_wait_cnt;

    // Held at zero outside ACCESS, so every ACCESS entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ACCESS)) begin
            r_wait_cnt <= '0;
        end else if (!w_sel_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_wait_cnt == c_wait_last) && !w_sel_ready;
`else
    // Watchdog compiled out: ACCESS waits for PREADY indefinitely.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rsp_fire  = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = '0;
        bus.PSEL    = '0;
        bus.PENABLE = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_req_hit ? SETUP : DERR;
                end
            end
            SETUP: begin
                bus.PSEL    = w_psel_idx;
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.PSEL    = w_psel_idx;
                bus.PENABLE = 1'b1;
                if (w_sel_ready) begin
                    w_state_nxt = IDLE;
                    w_rsp_fire  = 1'b1;
                    w_rsp_err   = w_sel_err;
                    w_rsp_rdata = (!bus.PWRITE && !w_sel_err) ? w_sel_rdata : '0;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_rsp_fire  = 1'b1;
                    w_rsp_err   = 1'b1;
                end
            end
            DERR: begin
                w_state_nxt = IDLE;
                w_rsp_fire  = 1'b1;
                w_rsp_err   = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus address/data hold their last values between transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx         <= '0;
            bus.PADDR     <= '0;
            bus.PWRITE    <= 1'b0;
            bus.PWDATA    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_idx      <= w_req_idx;
                bus.PADDR  <= bus.req_addr;
                bus.PWRITE <= bus.req_write;
                bus.PWDATA <= bus.req_wdata;
            end
            bus.rsp_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                bus.rsp_err   <= w_rsp_err;
                bus.rsp_rdata <= w_rsp_rdata;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_apb_interconnect_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apb_interconnect_n : transaction-schedule model + directed/random run  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_apb_interconnect_n;
    localparam int NS = 6;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;

    apb_interconnect_n_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_interconnect_n #(
        .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    bit force3 = 1'b0;

    // Pending slave behaviour for the request currently offered.
    int          p_wait;
    bit          p_err;
    logic [DW-1:0] p_rdata;

    // Model: one scheduled transaction, expressed as cycle numbers.
    int          m_free = 0;
    bit          acc_flag = 1'b0;
    bit          t_act = 1'b0;
    bit          t_hit;
    bit          t_to;
    int          t_idx, t_setup, t_acc_s, t_acc_e, t_rsp;
    bit          t_slv_err;
    bit          t_err_exp;
    logic [DW-1:0] t_prdata, t_rdata_exp;
    logic [AW-1:0] m_paddr = '0;
    bit            m_pwrite = 1'b0;
    logic [DW-1:0] m_pwdata = '0;
    bit            m_rsp_err = 1'b0;
    logic [DW-1:0] m_rsp_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    initial begin : model
        int k;
        int w;
        forever begin
            @(posedge clk);
            k = cyc;
            acc_flag = 1'b0;
            if (rst) begin
                t_act = 1'b0;  m_free = k + 1;
                m_paddr = '0;  m_pwrite = 1'b0;  m_pwdata = '0;
                m_rsp_err = 1'b0;  m_rsp_rdata = '0;
            end else if (bus.req_valid && k >= m_free) begin
                acc_flag = 1'b1;
                m_paddr  = bus.req_addr;
                m_pwrite = bus.req_write;
                m_pwdata = bus.req_wdata;
                t_act    = 1'b1;
                t_idx    = int'(bus.req_addr[AW-1 -: IW]);
                t_hit    = (t_idx < NS);
                t_prdata = p_rdata;
                t_slv_err = p_err;
                w = p_wait;
                t_to = 1'b0;
`ifdef APB_TIMEOUT_EN
                t_to = (w >= TO);
`endif
                if (!t_hit) begin
                    t_rsp = k + 2;  t_err_exp = 1'b1;  t_rdata_exp = '0;
                end else if (t_to) begin
                    t_setup = k + 1;  t_acc_s = k + 2;  t_acc_e = k + 1 + TO;
                    t_rsp = k + 2 + TO;  t_err_exp = 1'b1;  t_rdata_exp = '0;
                end else begin
                    t_setup = k + 1;  t_acc_s = k + 2;  t_acc_e = k + 2 + w;
                    t_rsp = k + 3 + w;  t_err_exp = p_err;
                    t_rdata_exp = (!bus.req_write && !p_err) ? p_rdata : '0;
                end
                m_free = t_rsp;
            end
            cyc = k + 1;
            if (t_act && cyc == t_rsp) begin
                m_rsp_err = t_err_exp;  m_rsp_rdata = t_rdata_exp;
            end
            if (t_act && cyc > t_rsp) t_act = 1'b0;
        end
    end

    // Slaves: noise everywhere, scheduled behaviour on the addressed slave in ACCESS.
    initial begin : slaves
        bus.PREADY = '0;  bus.PSLVERR = '0;  bus.PRDATA = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                bus.PREADY[i]  = 1'($urandom);
                bus.PSLVERR[i] = 1'($urandom);
                bus.PRDATA[i*DW +: DW] = $urandom;
            end
            if (force3) begin
                bus.PREADY[3] = 1'b1;
                bus.PRDATA[3*DW +: DW] = '1;
            end
            if (t_act && t_hit && cyc >= t_acc_s && cyc <= t_acc_e) begin
                bus.PREADY[t_idx] = (cyc == t_acc_e) && !t_to;
                if (cyc == t_acc_e) bus.PSLVERR[t_idx] = t_slv_err;
                bus.PRDATA[t_idx*DW +: DW] = t_prdata;
            end
        end
    end

    initial begin : compare
        int c;
        bit in_setup, in_acc;
        logic [NS-1:0] ep;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                c = cyc;
                in_setup = t_act && t_hit && (c == t_setup);
                in_acc   = t_act && t_hit && (c >= t_acc_s) && (c <= t_acc_e);
                ep = '0;
                if (in_setup || in_acc) ep[t_idx] = 1'b1;
                chk("req_ready", bus.req_ready, (c >= m_free) && !rst);
                chk("psel", bus.PSEL, ep);
                chk("psel_onehot", ($countones(bus.PSEL) <= 1), 1'b1);
                chk("penable", bus.PENABLE, in_acc);
                chk("paddr", bus.PADDR, m_paddr);
                chk("pwrite", bus.PWRITE, m_pwrite);
                chk("pwdata", bus.PWDATA, m_pwdata);
                chk("rsp_valid", bus.rsp_valid, t_act && (c == t_rsp));
                chk("rsp_err", bus.rsp_err, m_rsp_err);
                chk("rsp_rdata", bus.rsp_rdata, m_rsp_rdata);
            end
        end
    end

    // Offer a request, hold it until the model accepts, then drop req_valid.
    task automatic send(input logic [AW-1:0] a, input bit w, input logic [DW-1:0] wd,
                        input int wt, input bit e, input logic [DW-1:0] rd);
        int n;
        bus.req_valid = 1'b1;  bus.req_addr = a;  bus.req_write = w;  bus.req_wdata = wd;
        p_wait = wt;  p_err = e;  p_rdata = rd;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acc_flag && n < 200);
        chk("accept_wait", acc_flag, 1'b1);
        bus.req_valid = 1'b0;
        bus.req_addr  = AW'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_wdata = $urandom;
    endtask

    initial begin : stim
        logic [IW-1:0] ridx;
        int n;
        rst = 1'b1;
        bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;
        p_wait = 0;  p_err = 1'b0;  p_rdata = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_psel", bus.PSEL, 6'b000000);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_paddr", bus.PADDR, 12'h000);
        chk("reset_ready_low", bus.req_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Zero-wait write to slave 1.
        send(12'h2A4, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0BADF00D);
        @(negedge clk);
        chk("t1_setup", {bus.PSEL, bus.PENABLE}, {6'b000010, 1'b0});
        @(negedge clk);
        chk("t1_access", {bus.PSEL, bus.PENABLE}, {6'b000010, 1'b1});
        @(negedge clk);
        chk("t1_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b0, 32'h0});

        // Read from slave 4 with three wait states.
        send(12'h9F0, 1'b0, 32'h0, 3, 1'b0, 32'h12345678);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("t2_paddr_stable", bus.PADDR, 12'h9F0);
            chk("t2_no_rsp_yet", bus.rsp_valid, 1'b0);
        end
        @(negedge clk);
        chk("t2_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b0, 32'h12345678});

        // Decode miss.
        send(12'hE00, 1'b0, 32'h0, 0, 1'b0, 32'h55555555);
        @(negedge clk);
        chk("t3_no_psel", bus.PSEL, 6'b000000);
        @(negedge clk);
        chk("t3_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b1, 32'h0});

        // Slave error on slave 2 while slave 3 shouts.
        force3 = 1'b1;
        send(12'h488, 1'b0, 32'h0, 1, 1'b1, 32'hA5A5A5A5);
        repeat (3) @(negedge clk);
        chk("t4_no_early_rsp", bus.rsp_valid, 1'b0);
        @(negedge clk);
        chk("t4_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b1, 32'h0});
        force3 = 1'b0;

        // Back-to-back writes, slave 0 then slave 5.
        send(12'h010, 1'b1, 32'h11112222, 0, 1'b0, 32'h0);
        fork
            send(12'hA10, 1'b1, 32'h33334444, 0, 1'b0, 32'h0);
            begin
                @(negedge clk);
                chk("t5_a_setup", bus.PSEL, 6'b000001);
                @(negedge clk);
                chk("t5_a_access", {bus.PSEL, bus.PENABLE}, {6'b000001, 1'b1});
                @(negedge clk);
                chk("t5_a_rsp", {bus.rsp_valid, bus.req_ready}, 2'b11);
                @(negedge clk);
                chk("t5_b_setup", bus.PSEL, 6'b100000);
            end
        join

        // Reset during ACCESS of a slow read.
        send(12'h2F0, 1'b0, 32'h0, 10, 1'b0, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_after_reset", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.req_ready},
            {6'b000000, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        #1;

`ifdef APB_TIMEOUT_EN
        send(12'h100, 1'b0, 32'h0, 1000, 1'b0, 32'h77777777);
        repeat (17) @(negedge clk);
        chk("to_no_early_rsp", bus.rsp_valid, 1'b0);
        @(negedge clk);
        chk("to_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b1, 32'h0});
`endif

        // Randomized traffic, including misses and back-to-back offers.
        for (int i = 0; i < 300; i++) begin
            ridx = IW'($urandom_range(0, 7));
            send({ridx, 9'($urandom)}, 1'($urandom), $urandom,
                 $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        n = 0;
        while (cyc < m_free + 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", (cyc >= m_free + 2), 1'b1);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
